// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack load/store issue, pipeline stall, MEM/WB outputs.
// Optional build macro MISALIGN_TRAP_EN traps misaligned word accesses instead of aligning them down.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              byte_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        rd_in,
   input  logic              link_in,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic [3:0]        dm_be,
   input  logic [DATA_W-1:0] dm_rdata,
   input  logic              dm_ack,
   output logic              stall,
   output logic [DATA_W-1:0] data_out,
   output logic [3:0]        rd_out,
   output logic              link_out,
   output logic              err_out
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_byte;
   logic              r_we;
   logic [3:0]        r_rd;
   logic              r_link;
   logic [7:0]        r_cnt;
   logic [DATA_W-1:0] r_data_out;
   logic [3:0]        r_rd_out;
   logic              r_link_out;
   logic              r_err;

   logic              w_mem_op;
   logic              w_trap;
   logic              w_timeout;
   logic [7:0]        w_lane;

   assign w_mem_op  = mem_read | mem_write;
   // r_cnt counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle is the last one.
   assign w_timeout = (r_cnt == TIMEOUT_LAST);

`ifdef MISALIGN_TRAP_EN
   assign w_trap = w_mem_op & ~byte_op & (addr[1:0] != 2'b00);
`else
   assign w_trap = 1'b0;
`endif

   always_comb begin
      w_lane = dm_rdata[7:0];
      case (r_addr[1:0])
         2'd0:    w_lane = dm_rdata[7:0];
         2'd1:    w_lane = dm_rdata[15:8];
         2'd2:    w_lane = dm_rdata[23:16];
         default: w_lane = dm_rdata[31:24];
      endcase
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_op && !w_trap) begin
               stall        = 1'b1;
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (dm_ack || w_timeout) w_next_state = IDLE;
            else                     stall        = 1'b1;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_byte     <= 1'b0;
         r_we       <= 1'b0;
         r_rd       <= '0;
         r_link     <= 1'b0;
         r_cnt      <= '0;
         r_data_out <= '0;
         r_rd_out   <= '0;
         r_link_out <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_trap) begin
                  r_data_out <= '0;
                  r_rd_out   <= '0;
                  r_link_out <= 1'b0;
                  r_err      <= 1'b1;
               end else if (w_mem_op) begin
                  r_addr     <= addr;
                  r_wdata    <= wdata;
                  r_byte     <= byte_op;
                  r_we       <= mem_write;
                  r_rd       <= rd_in;
                  r_link     <= link_in;
                  r_data_out <= '0;
                  r_rd_out   <= '0;
                  r_link_out <= 1'b0;
               end else begin
                  r_data_out <= '0;
                  r_rd_out   <= rd_in;
                  r_link_out <= link_in;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (dm_ack) begin
                  if (r_we)        r_data_out <= '0;
                  else if (r_byte) r_data_out <= DATA_W'(w_lane);
                  else             r_data_out <= dm_rdata;
                  r_rd_out   <= r_rd;
                  r_link_out <= r_link;
               end else if (w_timeout) begin
                  r_data_out <= '0;
                  r_rd_out   <= '0;
                  r_link_out <= 1'b0;
                  r_err      <= 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Request-side outputs are zero outside WAIT and held from the latched request inside it.
   assign dm_req   = (r_state == WAIT);
   assign dm_we    = dm_req & r_we;
   assign dm_addr  = dm_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign dm_wdata = !dm_req ? '0 : (r_byte ? {4{r_wdata[7:0]}} : r_wdata);
   assign dm_be    = !dm_req ? 4'b0000 : (r_byte ? 4'(4'b0001 << r_addr[1:0]) : 4'b1111);

   assign data_out = r_data_out;
   assign rd_out   = r_rd_out;
   assign link_out = r_link_out;
   assign err_out  = r_err;

endmodule
